// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer.
// Sits between fetch and decode. in_ready is a flop, so decode back-pressure
// never reaches fetch combinationally. The second (skid) entry catches the one
// word fetch may already have sent before it sees in_ready drop.
// Flush squashes everything held. When no entry is valid, the outputs show
// PC 0 and the NOP instruction.
// Optional: define IF_ID_PERF_EN to add saturating bubble/stall/flush counters.
module if_id_skid_reg #(
  parameter int                PC_W     = 64,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;

  logic accept, drain, main_vld;

  // The main entry is valid whenever the register holds anything.
  // The skid entry is valid only in TWO.
  assign main_vld = (state_q != EMPTY);
  assign accept   = in_valid && in_ready_q;
  assign drain    = main_vld && out_ready;

  // Next state and data-register loads. Flush overrides accept and drain,
  // and it also blocks any data load in that cycle.
  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
          end else if (accept) begin
            state_d     = TWO;
            skid_pc_d   = in_pc;
            skid_inst_d = in_inst;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (drain) begin
            state_d     = ONE;
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Ready for the next cycle comes from the next state, so it is a pure flop.
  assign in_ready_d = (state_d != TWO);

  // State, ready and data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_pc_q   <= '0;
      main_inst_q <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld;
  assign out_pc    = main_vld ? main_pc_q   : '0;
  assign out_inst  = main_vld ? main_inst_q : NOP_INST;

`ifdef IF_ID_PERF_EN
  logic [31:0] bubble_q, stall_q;
  logic [15:0] flush_q;

  // Saturating event counters. Only reset clears them; flush does not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      if (!main_vld && out_ready && (bubble_q != '1))   bubble_q <= bubble_q + 32'd1;
      if (in_valid && !in_ready_q && (stall_q != '1))   stall_q  <= stall_q + 32'd1;
      if (flush && (flush_q != '1))                     flush_q  <= flush_q + 16'd1;
    end
  end

  assign perf_bubble_cnt = bubble_q;
  assign perf_stall_cnt  = stall_q;
  assign perf_flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Randomised bench for if_id_skid_reg.
// The reference model is a FIFO of up to two entries with a registered ready.
module tb_if_id_skid_reg;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [63:0] in_pc, out_pc;
  logic [31:0] in_inst, out_inst;
`ifdef IF_ID_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
  longint      m_bub, m_stl, m_fl;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t mq[$];
  bit   rdy_m;

  always #5 clk = ~clk;

  if_id_skid_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
`ifdef IF_ID_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    rdy_m = 1'b1;
`ifdef IF_ID_PERF_EN
    m_bub = 0; m_stl = 0; m_fl = 0;
`endif
  endtask

  task automatic check_outs();
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
    chk("out_pc",    out_pc,             mq.size() != 0 ? mq[0].pc : 64'd0);
    chk("out_inst",  {32'd0, out_inst},  {32'd0, mq.size() != 0 ? mq[0].inst : NOP});
    chk("in_ready",  {63'd0, in_ready},  {63'd0, rdy_m});
`ifdef IF_ID_PERF_EN
    chk("perf_bubble", {32'd0, perf_bubble_cnt}, m_bub[63:0]);
    chk("perf_stall",  {32'd0, perf_stall_cnt},  m_stl[63:0]);
    chk("perf_flush",  {48'd0, perf_flush_cnt},  m_fl[63:0]);
`endif
  endtask

  // Models one clock edge using the inputs that are stable across that edge.
  task automatic model_edge();
    bit acc, drn;
    if (!reset) begin
      model_clear();
      return;
    end
`ifdef IF_ID_PERF_EN
    if (mq.size() == 0 && out_ready && m_bub != 64'hFFFF_FFFF) m_bub++;
    if (in_valid && !rdy_m && m_stl != 64'hFFFF_FFFF)          m_stl++;
    if (flush && m_fl != 64'hFFFF)                              m_fl++;
`endif
    if (flush) begin
      mq.delete();
    end else begin
      acc = in_valid && rdy_m;
      drn = (mq.size() != 0) && out_ready;
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: in_pc, inst: in_inst});
    end
    rdy_m = (mq.size() < 2);
  endtask

  // Drives one cycle of inputs from a negedge, then checks at the next negedge.
  task automatic cyc(input logic v, input logic [63:0] pc, input logic fl, input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = pc[31:0] ^ 32'hA5A5_0000;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b1; in_pc = 64'h100; in_inst = 32'hdead;
    flush = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_outs();
    chk("rst_out_inst", {32'd0, out_inst}, 64'h13);
    reset = 1'b1;

    // After reset is released, the first accept shows up one cycle later.
    cyc(1, 64'h100, 0, 0);
    chk("first_accept_pc", out_pc, 64'h100);
    cyc(0, 0, 0, 1);

    // Back-to-back streaming.
    for (int i = 0; i < 4; i++) cyc(1, 64'(i * 4), 0, 1);
    cyc(0, 0, 0, 1);

    // Back-pressure. The third word has to wait upstream until ready returns.
    cyc(1, 64'h0, 0, 0);
    cyc(1, 64'h4, 0, 0);
    chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
    cyc(1, 64'h8, 0, 0);
    for (int i = 0; i < 4; i++) cyc(i < 2, 64'h8, 0, 1);

    // Flush while both entries are held and an input is being offered.
    cyc(1, 64'h10, 0, 0);
    cyc(1, 64'h14, 0, 0);
    cyc(1, 64'h20, 1, 0);
    chk("flush_nop", {32'd0, out_inst}, 64'h13);
    cyc(1, 64'h24, 0, 1);
    chk("post_flush_pc", out_pc, 64'h24);
    cyc(0, 0, 0, 1);

    // Accept and drain in the same cycle.
    cyc(1, 64'h40, 0, 0);
    cyc(1, 64'h44, 0, 1);
    chk("acc_drain_pc", out_pc, 64'h44);
    cyc(0, 0, 0, 1);

    // Bubble and flush counting on an empty register.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    // Randomised traffic with occasional flushes, plus one asynchronous reset.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        #2 reset = 1'b0;
        #1 model_clear();
        check_outs();
        @(negedge clk);
        reset = 1'b1;
      end
      cyc($urandom_range(0, 3) != 0, 64'($urandom) << 2, $urandom_range(0, 19) == 0,
          $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
